// File: rtl/uart_tx.sv
// Purpose : UART transmitter; start bit, 5-8 data bits LSB first, optional even parity, 1/1.5/2 stop bits.
// Latency : tx_o drives the start bit the cycle after an accepted start; each bit lasts OVERSAMPLE baud ticks.
// Backpres: tx_start_i is only sampled in IDLE; starts during a frame are dropped, not queued.
// Ports   : clk_i/rst_ni (sync active-low), baud_x16_tick_i, tx_en_i, tx_start_i,
//           tx_conf_i = {data[1:0], stop[1:0], parity_en}, tx_data_i;
//           tx_o (idle high), tx_busy_o (frame in progress), tx_done_o (1-cycle end-of-frame pulse).
module uart_tx #(
    parameter int MAX_UART_DATA_W = 8,
    parameter int STOP_CONF_W     = 2,
    parameter int DATA_CONF_W     = 2,
    parameter int TOTAL_CONF_W    = STOP_CONF_W + DATA_CONF_W + 1,
    parameter int OVERSAMPLE      = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       baud_x16_tick_i,
    input  logic                       tx_en_i,
    input  logic                       tx_start_i,
    input  logic [TOTAL_CONF_W-1:0]    tx_conf_i,
    input  logic [MAX_UART_DATA_W-1:0] tx_data_i,
    output logic                       tx_o,
    output logic                       tx_busy_o,
    output logic                       tx_done_o
);

    // Counter must reach 2*OVERSAMPLE-1 for two stop bits.
    localparam int TICK_W   = $clog2(2 * OVERSAMPLE);
    localparam int BIT_W    = $clog2(MAX_UART_DATA_W);
    // Smallest character width selectable by the data config field (5 for the default sizes).
    localparam int DATA_MIN = MAX_UART_DATA_W - (2 ** DATA_CONF_W) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_e;

    state_e                      state_q, state_d;
    logic [TICK_W-1:0]           tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]            bit_cnt_q, bit_cnt_d;
    logic [MAX_UART_DATA_W-1:0]  shift_q, shift_d;
    logic [DATA_CONF_W-1:0]      data_len_q, data_len_d;
    logic [STOP_CONF_W-1:0]      stop_cfg_q, stop_cfg_d;
    logic                        par_en_q, par_en_d;
    logic                        par_q, par_d;
    logic                        tx_q, tx_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;

    logic [DATA_CONF_W-1:0]      conf_data;
    logic [STOP_CONF_W-1:0]      conf_stop;
    logic                        conf_par;
    logic [MAX_UART_DATA_W-1:0]  data_mask;
    logic [BIT_W-1:0]            last_bit_idx;
    logic [TICK_W-1:0]           stop_last;
    logic                        bit_end;

    assign conf_data = tx_conf_i[TOTAL_CONF_W-1 -: DATA_CONF_W];
    assign conf_stop = tx_conf_i[STOP_CONF_W:1];
    assign conf_par  = tx_conf_i[0];

    // Mask computed from the incoming config so unused upper data bits never
    // reach the shift register or the parity XOR.
    always_comb begin
        data_mask = '0;
        for (int i = 0; i < MAX_UART_DATA_W; i++) begin
            data_mask[i] = (i < DATA_MIN + int'(conf_data));
        end
    end

    assign last_bit_idx = BIT_W'(DATA_MIN - 1) + BIT_W'(data_len_q);
    assign bit_end      = baud_x16_tick_i && (tick_cnt_q == TICK_W'(OVERSAMPLE - 1));

    always_comb begin
        if (stop_cfg_q == '0) begin
            stop_last = TICK_W'(OVERSAMPLE - 1);
        end else if (stop_cfg_q == STOP_CONF_W'(1)) begin
            stop_last = TICK_W'(OVERSAMPLE + OVERSAMPLE / 2 - 1);
        end else begin
            stop_last = TICK_W'(2 * OVERSAMPLE - 1);
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_len_d = data_len_q;
        stop_cfg_d = stop_cfg_q;
        par_en_d   = par_en_q;
        par_d      = par_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        // tx_d/busy_d describe the level of the cycle following a transition,
        // which keeps every output registered.
        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (tx_en_i && tx_start_i) begin
                    shift_d    = tx_data_i & data_mask;
                    par_d      = ^(tx_data_i & data_mask);
                    data_len_d = conf_data;
                    stop_cfg_d = conf_stop;
                    par_en_d   = conf_par;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                if (baud_x16_tick_i) begin
                    if (bit_end) begin
                        tick_cnt_d = '0;
                        tx_d       = shift_q[0];
                        state_d    = S_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (baud_x16_tick_i) begin
                    if (bit_end) begin
                        tick_cnt_d = '0;
                        if (bit_cnt_q == last_bit_idx) begin
                            if (par_en_q) begin
                                tx_d    = par_q;
                                state_d = S_PARITY;
                            end else begin
                                tx_d    = 1'b1;
                                state_d = S_STOP;
                            end
                        end else begin
                            // shift_q[0] is the bit on the line; [1] is next.
                            bit_cnt_d = bit_cnt_q + 1'b1;
                            shift_d   = shift_q >> 1;
                            tx_d      = shift_q[1];
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (baud_x16_tick_i) begin
                    if (bit_end) begin
                        tick_cnt_d = '0;
                        tx_d       = 1'b1;
                        state_d    = S_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (baud_x16_tick_i) begin
                    if (tick_cnt_q == stop_last) begin
                        tick_cnt_d = '0;
                        tx_d       = 1'b1;
                        busy_d     = 1'b0;
                        done_d     = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Losing the enable abandons the frame outright; it wins over a
        // coincident end of frame, so no done pulse is produced.
        if (!tx_en_i && (state_q != S_IDLE)) begin
            state_d    = S_IDLE;
            tick_cnt_d = '0;
            bit_cnt_d  = '0;
            tx_d       = 1'b1;
            busy_d     = 1'b0;
            done_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_len_q <= '0;
            stop_cfg_q <= '0;
            par_en_q   <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_len_q <= data_len_d;
            stop_cfg_q <= stop_cfg_d;
            par_en_q   <= par_en_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign tx_o      = tx_q;
    assign tx_busy_o = busy_q;
    assign tx_done_o = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Purpose : directed bench for uart_tx; frames are captured as one line level per baud tick.
// Latency : expected per-bit tick counts are hand-derived (16 per bit, 16/24/32 for stop).
// Backpres: covers starts while busy, starts in the done cycle and enable drop mid-frame.
module tb_uart_tx;

    typedef int iq_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       tx_en = 1'b0;
    logic       tx_start = 1'b0;
    logic [4:0] tx_conf = '0;
    logic [7:0] tx_data = '0;
    logic       tx_o;
    logic       tx_busy;
    logic       tx_done;

    int checks = 0;
    int failures = 0;

    // Baud tick generator: period 0 = no ticks, 1 = every cycle, N = every Nth.
    int tick_period = 1;
    int tick_phase  = 0;

    // Capture results.
    int got_q[$];
    int busy_cyc;
    int capt_to;
    logic d_busy;
    logic d_tx;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        if (tick_period <= 0) begin
            tick = 1'b0;
        end else begin
            tick = (tick_phase == 0);
            tick_phase = (tick_phase + 1) % tick_period;
        end
    end

    uart_tx dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .baud_x16_tick_i (tick),
        .tx_en_i         (tx_en),
        .tx_start_i      (tx_start),
        .tx_conf_i       (tx_conf),
        .tx_data_i       (tx_data),
        .tx_o            (tx_o),
        .tx_busy_o       (tx_busy),
        .tx_done_o       (tx_done)
    );

    // Expand hand-written per-bit levels into one entry per baud tick; the
    // last entry is the stop bit and lasts stop_ticks.
    function automatic iq_t expand(input int lv[$], input int stop_ticks);
        iq_t q;
        for (int j = 0; j < lv.size(); j++) begin
            int n = (j == lv.size() - 1) ? stop_ticks : 16;
            for (int k = 0; k < n; k++) q.push_back(lv[j]);
        end
        return q;
    endfunction

    // Present a start for one cycle; returns at the sample point of the first
    // frame cycle. The tick phase is set so that with period N the first
    // counted tick lands N cycles after acceptance.
    task automatic start_frame(input logic [4:0] conf, input logic [7:0] data);
        @(negedge clk);
        tx_conf = conf;
        tx_data = data;
        tx_start = 1'b1;
        tick_phase = (tick_period == 1) ? 0 : 1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Record the line level on every ticked cycle until tx_done (no checking).
    // mid_at >= 0 pulses tx_start with new data at that frame cycle.
    task automatic capture(input int budget, input int mid_at, input logic [7:0] mid_data);
        int cyc = 0;
        got_q.delete();
        busy_cyc = 0;
        capt_to = 0;
        forever begin
            if (tx_done === 1'b1) begin
                d_busy = tx_busy;
                d_tx   = tx_o;
                break;
            end
            if (tx_busy === 1'b1) busy_cyc++;
            if (tick) got_q.push_back(int'(tx_o));
            if (cyc == mid_at) begin
                tx_start = 1'b1;
                tx_data  = mid_data;
            end else begin
                tx_start = 1'b0;
            end
            if (cyc >= budget) begin
                capt_to = 1;
                break;
            end
            cyc++;
            @(negedge clk);
        end
        tx_start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tx_en = 1'b1;
        tx_start = 1'b1;
        tx_conf = 5'b11000;
        tx_data = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({tx_o, tx_busy, tx_done} !== 3'b100) begin
                failures++;
                $display("FAIL reset_hold[%0d] got tx/busy/done=%b required=100", i, {tx_o, tx_busy, tx_done});
            end
        end
        rst_n = 1'b1;
        tx_start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_o, tx_busy, tx_done} !== 3'b100) begin
            failures++;
            $display("FAIL reset_release got tx/busy/done=%b required=100", {tx_o, tx_busy, tx_done});
        end
    endtask

    task automatic test_8n1;
        iq_t exp;
        int bad;
        tick_period = 1;
        start_frame(5'b11000, 8'hA5);
        capture(400, -1, 8'h00);
        exp = expand('{0, 1, 0, 1, 0, 0, 1, 0, 1, 1}, 16);
        checks++;
        if (capt_to != 0) begin
            failures++;
            $display("FAIL 8n1_timeout got no done required done within 400 cycles");
        end
        bad = 0;
        for (int i = 0; i < exp.size() && i < got_q.size(); i++) if (got_q[i] !== exp[i]) bad++;
        checks++;
        if (got_q.size() != exp.size() || bad != 0) begin
            failures++;
            $display("FAIL 8n1_levels got ticks=%0d bad=%0d required ticks=%0d bad=0", got_q.size(), bad, exp.size());
        end
        checks++;
        if (busy_cyc != 160) begin
            failures++;
            $display("FAIL 8n1_busy got %0d required 160", busy_cyc);
        end
        checks++;
        if ({d_busy, d_tx} !== 2'b01) begin
            failures++;
            $display("FAIL 8n1_done_cycle got busy/tx=%b required 01", {d_busy, d_tx});
        end
        @(negedge clk);
        checks++;
        if (tx_done !== 1'b0) begin
            failures++;
            $display("FAIL 8n1_done_width got done=%b required 0", tx_done);
        end
    endtask

    task automatic test_5e15;
        iq_t exp;
        int bad;
        tick_period = 1;
        // 0xF3 low 5 bits 1,1,0,0,1 -> three ones -> parity 1.
        start_frame(5'b00011, 8'hF3);
        capture(400, -1, 8'h00);
        exp = expand('{0, 1, 1, 0, 0, 1, 1, 1}, 24);
        bad = 0;
        for (int i = 0; i < exp.size() && i < got_q.size(); i++) if (got_q[i] !== exp[i]) bad++;
        checks++;
        if (capt_to != 0 || got_q.size() != 136 || bad != 0) begin
            failures++;
            $display("FAIL 5e15_levels got ticks=%0d bad=%0d timeout=%0d required ticks=136 bad=0", got_q.size(), bad, capt_to);
        end
        checks++;
        if (busy_cyc != 136) begin
            failures++;
            $display("FAIL 5e15_busy got %0d required 136", busy_cyc);
        end
    endtask

    task automatic test_6e2_slow;
        iq_t exp;
        int bad;
        tick_period = 4;
        // 0xC0: bits 6,7 are outside a 6-bit character -> all data 0, parity 0.
        start_frame(5'b01101, 8'hC0);
        capture(1000, -1, 8'h00);
        exp = expand('{0, 0, 0, 0, 0, 0, 0, 0, 1}, 32);
        bad = 0;
        for (int i = 0; i < exp.size() && i < got_q.size(); i++) if (got_q[i] !== exp[i]) bad++;
        checks++;
        if (capt_to != 0 || got_q.size() != 160 || bad != 0) begin
            failures++;
            $display("FAIL 6e2_levels got ticks=%0d bad=%0d timeout=%0d required ticks=160 bad=0", got_q.size(), bad, capt_to);
        end
        checks++;
        if (busy_cyc != 640) begin
            failures++;
            $display("FAIL 6e2_busy got %0d required 640", busy_cyc);
        end
        tick_period = 1;
    endtask

    task automatic test_back_to_back;
        iq_t exp;
        int bad;
        tick_period = 1;
        // Mid-frame start with new data must be ignored; frame stays 0x3C.
        start_frame(5'b11000, 8'h3C);
        capture(400, 50, 8'hFF);
        exp = expand('{0, 0, 0, 1, 1, 1, 1, 0, 0, 1}, 16);
        bad = 0;
        for (int i = 0; i < exp.size() && i < got_q.size(); i++) if (got_q[i] !== exp[i]) bad++;
        checks++;
        if (capt_to != 0 || got_q.size() != exp.size() || bad != 0 || busy_cyc != 160) begin
            failures++;
            $display("FAIL b2b_first got ticks=%0d bad=%0d busy=%0d required ticks=160 bad=0 busy=160", got_q.size(), bad, busy_cyc);
        end
        // Start presented in the done cycle.
        tx_start = 1'b1;
        tx_data = 8'h81;
        tx_conf = 5'b11000;
        @(negedge clk);
        tx_start = 1'b0;
        checks++;
        if ({tx_o, tx_busy, tx_done} !== 3'b010) begin
            failures++;
            $display("FAIL b2b_gap got tx/busy/done=%b required 010", {tx_o, tx_busy, tx_done});
        end
        capture(400, -1, 8'h00);
        exp = expand('{0, 1, 0, 0, 0, 0, 0, 0, 1, 1}, 16);
        bad = 0;
        for (int i = 0; i < exp.size() && i < got_q.size(); i++) if (got_q[i] !== exp[i]) bad++;
        checks++;
        if (capt_to != 0 || got_q.size() != exp.size() || bad != 0) begin
            failures++;
            $display("FAIL b2b_second got ticks=%0d bad=%0d required ticks=160 bad=0", got_q.size(), bad);
        end
    endtask

    task automatic test_enable_drop;
        iq_t exp;
        int bad;
        int seen;
        tick_period = 1;
        start_frame(5'b11000, 8'h55);
        repeat (40) @(negedge clk);
        // Frame cycle 41 is inside data bit 1 (0x55 bit1 = 0).
        checks++;
        if ({tx_o, tx_busy} !== 2'b01) begin
            failures++;
            $display("FAIL endrop_pre got tx/busy=%b required 01", {tx_o, tx_busy});
        end
        tx_en = 1'b0;
        @(negedge clk);
        checks++;
        if ({tx_o, tx_busy, tx_done} !== 3'b100) begin
            failures++;
            $display("FAIL endrop_abort got tx/busy/done=%b required 100", {tx_o, tx_busy, tx_done});
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            tx_start = (i == 5);
            @(negedge clk);
            if ({tx_o, tx_busy, tx_done} !== 3'b100) seen++;
        end
        tx_start = 1'b0;
        checks++;
        if (seen != 0) begin
            failures++;
            $display("FAIL endrop_idle got %0d non-idle cycles required 0", seen);
        end
        tx_en = 1'b1;
        start_frame(5'b11000, 8'h55);
        capture(400, -1, 8'h00);
        exp = expand('{0, 1, 0, 1, 0, 1, 0, 1, 0, 1}, 16);
        bad = 0;
        for (int i = 0; i < exp.size() && i < got_q.size(); i++) if (got_q[i] !== exp[i]) bad++;
        checks++;
        if (capt_to != 0 || got_q.size() != exp.size() || bad != 0 || busy_cyc != 160) begin
            failures++;
            $display("FAIL endrop_resend got ticks=%0d bad=%0d busy=%0d required ticks=160 bad=0 busy=160", got_q.size(), bad, busy_cyc);
        end
    endtask

    task automatic test_no_ticks;
        iq_t exp;
        int bad;
        tick_period = 0;
        start_frame(5'b11000, 8'hA5);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ({tx_o, tx_busy} !== 2'b01) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL noticks_hold got %0d bad cycles required 0", bad);
        end
        tick_period = 1;
        capture(400, -1, 8'h00);
        exp = expand('{0, 1, 0, 1, 0, 0, 1, 0, 1, 1}, 16);
        bad = 0;
        for (int i = 0; i < exp.size() && i < got_q.size(); i++) if (got_q[i] !== exp[i]) bad++;
        checks++;
        if (capt_to != 0 || got_q.size() != exp.size() || bad != 0) begin
            failures++;
            $display("FAIL noticks_resume got ticks=%0d bad=%0d required ticks=160 bad=0", got_q.size(), bad);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_5e15();
        test_6e2_slow();
        test_back_to_back();
        test_enable_drop();
        test_no_ticks();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got simulation still running required completion");
        $fatal(1, "watchdog");
    end

endmodule
